// File: rtl/ins_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ins_encoder_pkg
// Description : Shared constants for the instruction encoder: request
//               operation codes, 6-bit MIPS opcode / funct fields and the
//               load-session FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package ins_encoder_pkg;

    // Request operation codes carried on in_op (13..15 are illegal)
    localparam logic [3:0] c_OP_ADDU  = 4'd0;
    localparam logic [3:0] c_OP_SUBU  = 4'd1;
    localparam logic [3:0] c_OP_SLT   = 4'd2;
    localparam logic [3:0] c_OP_JR    = 4'd3;
    localparam logic [3:0] c_OP_J     = 4'd4;
    localparam logic [3:0] c_OP_JAL   = 4'd5;
    localparam logic [3:0] c_OP_BEQ   = 4'd6;
    localparam logic [3:0] c_OP_ADDI  = 4'd7;
    localparam logic [3:0] c_OP_ADDIU = 4'd8;
    localparam logic [3:0] c_OP_ORI   = 4'd9;
    localparam logic [3:0] c_OP_LW    = 4'd10;
    localparam logic [3:0] c_OP_SW    = 4'd11;
    localparam logic [3:0] c_OP_LUI   = 4'd12;

    // Instruction opcode field [31:26]
    localparam logic [5:0] c_OPC_RTYPE = 6'b000000;
    localparam logic [5:0] c_OPC_J     = 6'b000010;
    localparam logic [5:0] c_OPC_JAL   = 6'b000011;
    localparam logic [5:0] c_OPC_BEQ   = 6'b000100;
    localparam logic [5:0] c_OPC_ADDI  = 6'b001000;
    localparam logic [5:0] c_OPC_ADDIU = 6'b001001;
    localparam logic [5:0] c_OPC_ORI   = 6'b001101;
    localparam logic [5:0] c_OPC_LUI   = 6'b001111;
    localparam logic [5:0] c_OPC_LW    = 6'b100011;
    localparam logic [5:0] c_OPC_SW    = 6'b101011;

    // R-type funct field [5:0]
    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUBU = 6'b100011;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_JR   = 6'b001000;

    // Load-session FSM states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ins_field_enc.sv
`default_nettype none
// ============================================================================
// Module      : ins_field_enc
// Description : Purely combinational field-to-word encoder. Packs an
//               operation code and its register/immediate/target fields
//               into a 32-bit MIPS instruction word.
// Ports       : i_op[3:0]        operation code
//               i_rs/i_rt/i_rd   register fields (5 bits each)
//               i_imm[15:0]      immediate
//               i_target[25:0]   jump target
//               o_word[31:0]     encoded instruction
//               o_illegal        op code has no encoding
// Revision    : 1.0 - initial release
// ============================================================================
module ins_field_enc
    import ins_encoder_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'd0;
        o_illegal = 1'b0;
        case (i_op)
            c_OP_ADDU:  o_word = {c_OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, c_FN_ADDU};
            c_OP_SUBU:  o_word = {c_OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, c_FN_SUBU};
            c_OP_SLT:   o_word = {c_OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, c_FN_SLT};
            // jr only uses rs; rt, rd and shamt are forced to zero
            c_OP_JR:    o_word = {c_OPC_RTYPE, i_rs, 15'd0, c_FN_JR};
            c_OP_J:     o_word = {c_OPC_J, i_target};
            c_OP_JAL:   o_word = {c_OPC_JAL, i_target};
            c_OP_BEQ:   o_word = {c_OPC_BEQ, i_rs, i_rt, i_imm};
            c_OP_ADDI:  o_word = {c_OPC_ADDI, i_rs, i_rt, i_imm};
            c_OP_ADDIU: o_word = {c_OPC_ADDIU, i_rs, i_rt, i_imm};
            c_OP_ORI:   o_word = {c_OPC_ORI, i_rs, i_rt, i_imm};
            c_OP_LW:    o_word = {c_OPC_LW, i_rs, i_rt, i_imm};
            c_OP_SW:    o_word = {c_OPC_SW, i_rs, i_rt, i_imm};
            // lui has no source register
            c_OP_LUI:   o_word = {c_OPC_LUI, 5'd0, i_rt, i_imm};
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ins_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ins_encoder
// Description : Accepts instruction requests over a valid/ready handshake,
//               encodes them and writes them to consecutive words of an
//               instruction memory during a start/finish load session.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               start, finish            open/restart and close a session
//               in_valid, in_ready       request handshake
//               in_op, in_rs, in_rt, in_rd, in_imm, in_target  request fields
//               im_we, im_addr, im_wdata instruction-memory write port
//               count                    words written this session
//               busy, done               session in LOAD / DONE
//               err_illegal, err_full    sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module ins_encoder
    import ins_encoder_pkg::*;
#(
    parameter int IM_AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [15:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      im_wdata,
    output logic [IM_AW:0]   count,
    output logic             busy,
    output logic             done,
    output logic             err_illegal,
    output logic             err_full
);

    localparam logic [IM_AW:0] c_ONE = {{IM_AW{1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [IM_AW:0]   r_count;
    logic             r_we;
    logic [IM_AW-1:0] r_addr;
    logic [31:0]      r_wdata;
    logic             r_ill;
    logic             r_full;
    logic             r_fin_pend;   // finish seen with a word still to write

    logic [31:0]      w_word;
    logic             w_illegal;
    logic             w_load;
    logic             w_mem_full;
    logic             w_accept;
    logic             w_write;

    ins_field_enc u_field_enc (
        .i_op      (in_op),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_rd      (in_rd),
        .i_imm     (in_imm),
        .i_target  (in_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_load     = (r_state == c_ST_LOAD);
    // count never exceeds the depth, so its MSB alone flags a full memory
    assign w_mem_full = r_count[IM_AW];
    assign in_ready   = w_load & ~w_mem_full & ~r_fin_pend & ~start & ~rst;
    assign w_accept   = in_valid & in_ready;
    assign w_write    = w_accept & ~w_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_ill      <= 1'b0;
            r_full     <= 1'b0;
            r_fin_pend <= 1'b0;
        end else if (start) begin
            r_state    <= c_ST_LOAD;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_fin_pend <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_load) begin
                if (w_write) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_count[IM_AW-1:0];
                    r_wdata <= w_word;
                    r_count <= r_count + c_ONE;
                end
                if (w_accept && w_illegal) begin
                    r_ill <= 1'b1;
                end
                if (in_valid && w_mem_full) begin
                    r_full <= 1'b1;
                end
                // A word accepted alongside finish is written first; the
                // session closes on the edge that ends its write cycle.
                if (r_fin_pend) begin
                    r_state    <= c_ST_DONE;
                    r_fin_pend <= 1'b0;
                end else if (finish) begin
                    if (w_write) begin
                        r_fin_pend <= 1'b1;
                    end else begin
                        r_state <= c_ST_DONE;
                    end
                end
            end
        end
    end

    // A write whose cycle coincides with rst or start is discarded so the
    // memory never sees a word from an aborted session.
    assign im_we       = r_we & ~rst & ~start;
    assign im_addr     = r_addr;
    assign im_wdata    = r_wdata;
    assign count       = r_count;
    assign busy        = w_load;
    assign done        = (r_state == c_ST_DONE);
    assign err_illegal = r_ill;
    assign err_full    = r_full;

endmodule
`default_nettype wire
